// File: rtl/rc_pkg.sv
// Shared lane masks, FSM state type and default LFSR constants for the
// round-constant sequencer.
package rc_pkg;

    localparam logic [3:0][7:0] RC_LANE_MASK = {8'h40, 8'h54, 8'h11, 8'h05};
    localparam logic [7:0]      DEFAULT_INIT = 8'h6C;
    localparam logic [7:0]      DEFAULT_TAPS = 8'hC6;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN,
        DONE
    } rc_state_t;

endpackage

// File: rtl/rc_lfsr_step.sv
// Combinational one-step LFSR advance in both directions; the inverse
// undoes the forward shift by recovering the bit that fell off the top.
module rc_lfsr_step
    import rc_pkg::*;
#(
    parameter int                LFSR_W = 8,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEFAULT_TAPS)
) (
    input  logic [LFSR_W-1:0] i_q,
    output logic [LFSR_W-1:0] o_next,
    output logic [LFSR_W-1:0] o_prev
);

    assign o_next = {i_q[LFSR_W-2:0], ^(i_q & TAPS)};
    assign o_prev = {i_q[0] ^ (^(i_q[LFSR_W-1:1] & TAPS[LFSR_W-2:0])), i_q[LFSR_W-1:1]};

endmodule

// File: rtl/rc_sequencer.sv
// Round-constant sequencer streaming LFSR-derived constants over valid/ready.
// Reverse order (dir, PRIME, inverse step) is built only with RC_SEQUENCER_REVERSE_EN.
module rc_sequencer
    import rc_pkg::*;
#(
    parameter int                LFSR_W = 8,
    parameter int                LANES  = 4,
    parameter int                ROUNDS = 16,
    parameter logic [LFSR_W-1:0] INIT   = LFSR_W'(DEFAULT_INIT),
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEFAULT_TAPS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        dir,
    input  logic                        clear,
    output logic                        rc_valid,
    input  logic                        rc_ready,
    output logic [LANES*LFSR_W-1:0]     rc_data,
    output logic [$clog2(ROUNDS)-1:0]   rc_round,
    output logic                        rc_last,
    output logic                        busy,
    output logic                        done
);

    localparam int             RW       = $clog2(ROUNDS);
    localparam logic [RW-1:0]  LAST_IDX = RW'(ROUNDS - 1);
    localparam logic [RW-1:0]  ONE      = RW'(1);

    rc_state_t                 r_state, w_stateNext;
    logic [LFSR_W-1:0]         r_q, w_qNext, w_next, w_prev;
    logic [RW-1:0]             r_round, w_roundNext;
    logic                      w_reverse, w_handshake;
    logic [LANES*LFSR_W-1:0]   w_lanes;

`ifdef RC_SEQUENCER_REVERSE_EN
    localparam logic [RW-1:0]  PRIME_END = RW'(ROUNDS - 2);
    logic                      r_dir, w_dirNext;
    assign w_reverse = r_dir;
`else
    logic                      w_unused_dirPrev;
    assign w_reverse        = 1'b0;
    assign w_unused_dirPrev = dir ^ (^w_prev);
`endif

    rc_lfsr_step #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS)
    ) u_step (
        .i_q    (r_q),
        .o_next (w_next),
        .o_prev (w_prev)
    );

    // The register holds s_r; the emitted constant is built from one step ahead.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign w_lanes[k*LFSR_W +: LFSR_W] = w_next ^ LFSR_W'(RC_LANE_MASK[k]);
    end

    assign rc_valid    = (r_state == RUN);
    assign busy        = (r_state == PRIME) || (r_state == RUN);
    assign done        = (r_state == DONE);
    assign rc_round    = r_round;
    assign rc_last     = rc_valid && (w_reverse ? (r_round == '0) : (r_round == LAST_IDX));
    assign rc_data     = rc_valid ? w_lanes : '0;
    assign w_handshake = rc_valid & rc_ready;

    always_comb begin
        w_stateNext = r_state;
        w_qNext     = r_q;
        w_roundNext = r_round;
`ifdef RC_SEQUENCER_REVERSE_EN
        w_dirNext   = r_dir;
`endif
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_qNext     = INIT;
                    w_roundNext = '0;
`ifdef RC_SEQUENCER_REVERSE_EN
                    w_dirNext   = dir;
                    w_stateNext = dir ? PRIME : RUN;
`else
                    w_stateNext = RUN;
`endif
                end
            end
`ifdef RC_SEQUENCER_REVERSE_EN
            // Walk forward to s_{ROUNDS-1}, using the round counter as the cycle count.
            PRIME: begin
                w_qNext     = w_next;
                w_roundNext = r_round + ONE;
                if (r_round == PRIME_END) begin
                    w_stateNext = RUN;
                end
            end
`endif
            RUN: begin
                if (w_handshake) begin
                    if (rc_last) begin
                        w_stateNext = DONE;
                    end
`ifdef RC_SEQUENCER_REVERSE_EN
                    else if (r_dir) begin
                        w_qNext     = w_prev;
                        w_roundNext = r_round - ONE;
                    end
`endif
                    else begin
                        w_qNext     = w_next;
                        w_roundNext = r_round + ONE;
                    end
                end
            end
            DONE:    w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
        if (clear) begin
            w_stateNext = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_q     <= INIT;
            r_round <= '0;
`ifdef RC_SEQUENCER_REVERSE_EN
            r_dir   <= 1'b0;
`endif
        end else begin
            r_state <= w_stateNext;
            r_q     <= w_qNext;
            r_round <= w_roundNext;
`ifdef RC_SEQUENCER_REVERSE_EN
            r_dir   <= w_dirNext;
`endif
        end
    end

endmodule

// File: tb/tb_rc_sequencer.sv
// Scoreboard bench for rc_sequencer: a default-parameter instance and a
// ROUNDS=2 instance; reverse-order scenarios follow RC_SEQUENCER_REVERSE_EN.
module tb_rc_sequencer;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  round;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, start, dir, clear, rcReady;
    logic        rcValid, rcLast, busy, done;
    logic [31:0] rcData;
    logic [3:0]  rcRound;

    logic        start2, dir2, clear2, rcReady2;
    logic        rcValid2, rcLast2, busy2, done2;
    logic [31:0] rcData2;
    logic [0:0]  rcRound2;

    exp_t        sbQ[$];
    exp_t        sbQ2[$];
    exp_t        sbE, sbE2;
    int          nChecks = 0;
    int          nFails  = 0;
    logic [7:0]  laneMask [4] = '{8'h05, 8'h11, 8'h54, 8'h40};

    always #5 clk = ~clk;

    rc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .clear(clear),
        .rc_valid(rcValid), .rc_ready(rcReady), .rc_data(rcData),
        .rc_round(rcRound), .rc_last(rcLast), .busy(busy), .done(done)
    );

    rc_sequencer #(.ROUNDS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .dir(dir2), .clear(clear2),
        .rc_valid(rcValid2), .rc_ready(rcReady2), .rc_data(rcData2),
        .rc_round(rcRound2), .rc_last(rcLast2), .busy(busy2), .done(done2)
    );

    // Independent reference: bitwise-parity LFSR walk from the seed.
    function automatic logic [7:0] modelStep(input logic [7:0] s);
        logic [7:0] taps = 8'hC6;
        logic       fb   = 1'b0;
        for (int i = 0; i < 8; i++) if (taps[i]) fb ^= s[i];
        return {s[6:0], fb};
    endfunction

    function automatic logic [31:0] modelConst(input int r);
        logic [7:0]  s = 8'h6C;
        logic [7:0]  n;
        logic [31:0] c;
        for (int i = 0; i < r; i++) s = modelStep(s);
        n = modelStep(s);
        for (int k = 0; k < 4; k++) c[k*8 +: 8] = n ^ laneMask[k];
        return c;
    endfunction

    task automatic pushForward();
        exp_t e;
        for (int r = 0; r < 16; r++) begin
            e.data  = modelConst(r);
            e.round = 4'(r);
            e.last  = (r == 15);
            sbQ.push_back(e);
        end
    endtask

    // Consumed constants are popped and compared a little after each falling edge.
    always @(negedge clk) begin
        #2;
        if (rcValid && rcReady) begin
            nChecks++;
            if (sbQ.size() == 0) begin
                nFails++;
                $display("[TB] FAIL sb_unexpected: got data=%h round=%0d, expected no constant", rcData, rcRound);
            end else begin
                sbE = sbQ.pop_front();
                if (rcData !== sbE.data || rcRound !== sbE.round || rcLast !== sbE.last) begin
                    nFails++;
                    $display("[TB] FAIL sb_const: got data=%h round=%0d last=%b, expected data=%h round=%0d last=%b",
                             rcData, rcRound, rcLast, sbE.data, sbE.round, sbE.last);
                end
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (rcValid2 && rcReady2) begin
            nChecks++;
            if (sbQ2.size() == 0) begin
                nFails++;
                $display("[TB] FAIL sb2_unexpected: got data=%h round=%0d, expected no constant", rcData2, rcRound2);
            end else begin
                sbE2 = sbQ2.pop_front();
                if (rcData2 !== sbE2.data || {3'b000, rcRound2} !== sbE2.round || rcLast2 !== sbE2.last) begin
                    nFails++;
                    $display("[TB] FAIL sb2_const: got data=%h round=%0d last=%b, expected data=%h round=%0d last=%b",
                             rcData2, rcRound2, rcLast2, sbE2.data, sbE2.round, sbE2.last);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic drainScoreboard(input int maxCyc, output int doneCnt);
        int cyc = 0;
        doneCnt = 0;
        while (sbQ.size() != 0 && cyc < maxCyc) begin
            @(negedge clk);
            cyc++;
            if (done) doneCnt++;
        end
        repeat (3) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; dir = 1'b0; clear = 1'b0; rcReady = 1'b0;
        start2 = 1'b0; dir2 = 1'b0; clear2 = 1'b0; rcReady2 = 1'b0;
        repeat (2) @(negedge clk);
        nChecks++;
        if (rcValid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL reset_ctrl: got valid=%b busy=%b done=%b, expected 0 0 0", rcValid, busy, done);
        end
        nChecks++;
        if (rcData !== 32'h0 || rcRound !== 4'd0 || rcLast !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL reset_data: got data=%h round=%0d last=%b, expected 0 0 0", rcData, rcRound, rcLast);
        end
        nChecks++;
        if (rcValid2 !== 1'b0 || busy2 !== 1'b0 || rcData2 !== 32'h0) begin
            nFails++;
            $display("[TB] FAIL reset_dut2: got valid=%b busy=%b data=%h, expected 0 0 0", rcValid2, busy2, rcData2);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_forward();
        int doneCnt;
        pushForward();
        dir = 1'b0; start = 1'b1; rcReady = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nChecks++;
        if (rcValid !== 1'b1 || rcData !== 32'h988CC9DD || rcRound !== 4'd0 || busy !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL fwd_first: got valid=%b data=%h round=%0d busy=%b, expected 1 988cc9dd 0 1",
                     rcValid, rcData, rcRound, busy);
        end
        drainScoreboard(40, doneCnt);
        nChecks++;
        if (sbQ.size() != 0) begin
            nFails++;
            $display("[TB] FAIL fwd_count: got %0d constants missing, expected 0", sbQ.size());
        end
        nChecks++;
        if (doneCnt !== 1) begin
            nFails++;
            $display("[TB] FAIL fwd_done: got %0d done pulses, expected 1", doneCnt);
        end
        nChecks++;
        if (rcValid !== 1'b0 || busy !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL fwd_idle: got valid=%b busy=%b, expected 0 0", rcValid, busy);
        end
    endtask

    task automatic test_stall();
        int doneCnt;
        pushForward();
        dir = 1'b0; start = 1'b1; rcReady = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rcReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = (i == 1);
            nChecks++;
            if (rcValid !== 1'b1 || rcData !== 32'hF0E4A1B5 || rcRound !== 4'd1) begin
                nFails++;
                $display("[TB] FAIL stall_hold: got valid=%b data=%h round=%0d, expected 1 f0e4a1b5 1",
                         rcValid, rcData, rcRound);
            end
        end
        start = 1'b0;
        rcReady = 1'b1;
        drainScoreboard(40, doneCnt);
        nChecks++;
        if (sbQ.size() != 0 || doneCnt !== 1) begin
            nFails++;
            $display("[TB] FAIL stall_drain: got missing=%0d done=%0d, expected 0 1", sbQ.size(), doneCnt);
        end
    endtask

    task automatic test_direction();
        int doneCnt;
`ifdef RC_SEQUENCER_REVERSE_EN
        int   primeCnt = 0;
        int   cyc      = 0;
        exp_t e;
        for (int r = 15; r >= 0; r--) begin
            e.data  = modelConst(r);
            e.round = 4'(r);
            e.last  = (r == 0);
            sbQ.push_back(e);
        end
        dir = 1'b1; start = 1'b1; rcReady = 1'b1;
        @(negedge clk);
        start = 1'b0; dir = 1'b0;
        while (!rcValid && cyc < 40) begin
            if (busy) primeCnt++;
            @(negedge clk);
            cyc++;
        end
        nChecks++;
        if (primeCnt !== 15 || rcRound !== 4'd15) begin
            nFails++;
            $display("[TB] FAIL rev_prime: got prime=%0d round=%0d, expected 15 15", primeCnt, rcRound);
        end
`else
        pushForward();
        dir = 1'b1; start = 1'b1; rcReady = 1'b1;
        @(negedge clk);
        start = 1'b0; dir = 1'b0;
        nChecks++;
        if (rcValid !== 1'b1 || rcRound !== 4'd0) begin
            nFails++;
            $display("[TB] FAIL dir_ignored: got valid=%b round=%0d, expected 1 0", rcValid, rcRound);
        end
`endif
        drainScoreboard(60, doneCnt);
        nChecks++;
        if (sbQ.size() != 0 || doneCnt !== 1) begin
            nFails++;
            $display("[TB] FAIL dir_drain: got missing=%0d done=%0d, expected 0 1", sbQ.size(), doneCnt);
        end
    endtask

    task automatic test_short_sequence();
        int primeCnt = 0;
        int doneCnt  = 0;
        int cyc      = 0;
        int expPrime;
`ifdef RC_SEQUENCER_REVERSE_EN
        expPrime = 1;
        sbQ2.push_back('{32'hF0E4A1B5, 4'd1, 1'b0});
        sbQ2.push_back('{32'h988CC9DD, 4'd0, 1'b1});
`else
        expPrime = 0;
        sbQ2.push_back('{32'h988CC9DD, 4'd0, 1'b0});
        sbQ2.push_back('{32'hF0E4A1B5, 4'd1, 1'b1});
`endif
        dir2 = 1'b1; start2 = 1'b1; rcReady2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0; dir2 = 1'b0;
        while (!rcValid2 && cyc < 10) begin
            if (busy2) primeCnt++;
            @(negedge clk);
            cyc++;
        end
        nChecks++;
        if (primeCnt !== expPrime) begin
            nFails++;
            $display("[TB] FAIL short_prime: got %0d prime cycles, expected %0d", primeCnt, expPrime);
        end
        repeat (6) begin
            @(negedge clk);
            if (done2) doneCnt++;
        end
        nChecks++;
        if (sbQ2.size() != 0 || doneCnt !== 1) begin
            nFails++;
            $display("[TB] FAIL short_drain: got missing=%0d done=%0d, expected 0 1", sbQ2.size(), doneCnt);
        end
    endtask

    task automatic test_clear();
        int cyc     = 0;
        int doneCnt = 0;
        pushForward();
        dir = 1'b0; start = 1'b1; rcReady = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (rcRound !== 4'd7 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        nChecks++;
        if (rcRound !== 4'd7 || rcValid !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL clear_reach: got round=%0d valid=%b, expected 7 1", rcRound, rcValid);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        nChecks++;
        if (rcValid !== 1'b0 || rcData !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL clear_idle: got valid=%b data=%h busy=%b done=%b, expected 0 0 0 0",
                     rcValid, rcData, busy, done);
        end
        sbQ.delete();
        repeat (4) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        nChecks++;
        if (doneCnt !== 0) begin
            nFails++;
            $display("[TB] FAIL clear_done: got %0d done pulses, expected 0", doneCnt);
        end
        clear = 1'b1; start = 1'b1;
        @(negedge clk);
        clear = 1'b0; start = 1'b0;
        nChecks++;
        if (rcValid !== 1'b0 || busy !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL clear_over_start: got valid=%b busy=%b, expected 0 0", rcValid, busy);
        end
    endtask

    task automatic test_reset_midrun();
        int cyc = 0;
        int doneCnt;
        pushForward();
        dir = 1'b0; start = 1'b1; rcReady = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (rcRound !== 4'd3 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        rst_n = 1'b0; start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;
        nChecks++;
        if (rcValid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rcData !== 32'h0 || rcRound !== 4'd0) begin
            nFails++;
            $display("[TB] FAIL rst_mid: got valid=%b busy=%b done=%b data=%h round=%0d, expected 0 0 0 0 0",
                     rcValid, busy, done, rcData, rcRound);
        end
        sbQ.delete();
        @(negedge clk);
        pushForward();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nChecks++;
        if (rcValid !== 1'b1 || rcData !== 32'h988CC9DD) begin
            nFails++;
            $display("[TB] FAIL rst_restart: got valid=%b data=%h, expected 1 988cc9dd", rcValid, rcData);
        end
        drainScoreboard(40, doneCnt);
        nChecks++;
        if (sbQ.size() != 0 || doneCnt !== 1) begin
            nFails++;
            $display("[TB] FAIL rst_drain: got missing=%0d done=%0d, expected 0 1", sbQ.size(), doneCnt);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_stall();
        test_direction();
        test_short_sequence();
        test_clear();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
